// File: rtl/window_buffer_kxk.sv
// window_buffer_kxk: parametrised KxK sliding window, one input column per accepted strobe.
// Rev 1.0
`default_nettype none

module window_buffer_kxk #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int COLS   = 11,
  parameter int ROWS   = 11
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             done_i,
  input  logic [K*DATA_W-1:0]              col_i,
  output logic [K*K*DATA_W-1:0]            window_o,
  output logic                             done_o,
  output logic [$clog2(ROWS)-1:0]          ctr_row_o,
  output logic [$clog2(COLS)-1:0]          ctr_col_o,
  output logic                             progress_done_o
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int HALF  = (K - 1) / 2;
  localparam int ROW_BITS = K * DATA_W;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_FILL_END = COL_W'(K - 2);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - K);
  localparam logic [ROW_W-1:0] CTR_OFF_R    = ROW_W'(HALF);
  localparam logic [COL_W-1:0] CTR_OFF_C    = COL_W'(HALF);
  localparam logic [COL_W-1:0] COL_ONE      = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE      = ROW_W'(1);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [COL_W-1:0]   col_cnt;
  logic [COL_W-1:0]   col_cnt_nxt;
  logic [ROW_W-1:0]   row_cnt;
  logic [ROW_W-1:0]   row_cnt_nxt;
  logic               col_wrap;
  logic               row_wrap;
  logic               win_valid;
  logic               frame_end;

  always_comb begin
    col_wrap  = (col_cnt == COL_LAST);
    row_wrap  = (row_cnt == ROW_LAST);
    // STREAM is held exactly while col_cnt >= K-1, so it doubles as the window-valid qualifier
    win_valid = done_i && (state == STREAM);
    frame_end = win_valid && col_wrap && row_wrap;
  end

  always_comb begin
    state_nxt   = state;
    col_cnt_nxt = col_cnt;
    row_cnt_nxt = row_cnt;
    if (done_i) begin
      col_cnt_nxt = col_wrap ? '0 : (col_cnt + COL_ONE);
      if (col_wrap) begin
        row_cnt_nxt = row_wrap ? '0 : (row_cnt + ROW_ONE);
      end
      case (state)
        FILL: begin
          if (col_cnt == COL_FILL_END) begin
            state_nxt = STREAM;
          end
        end
        STREAM: begin
          if (col_wrap) begin
            state_nxt = FILL;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_cnt_nxt;
      row_cnt <= row_cnt_nxt;
    end
  end

  // Each window row shifts toward element 0 (lower bits); the new lane enters at element K-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_o <= '0;
    end else if (done_i) begin
      for (int r = 0; r < K; r++) begin
        window_o[r*ROW_BITS +: ROW_BITS] <=
          {col_i[r*DATA_W +: DATA_W], window_o[r*ROW_BITS + DATA_W +: (K-1)*DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o          <= 1'b0;
      progress_done_o <= 1'b0;
      ctr_row_o       <= '0;
      ctr_col_o       <= '0;
    end else begin
      done_o          <= win_valid;
      progress_done_o <= frame_end;
      if (win_valid) begin
        ctr_row_o <= row_cnt + CTR_OFF_R;
        ctr_col_o <= col_cnt - CTR_OFF_C;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_buffer_kxk.sv
// tb_window_buffer_kxk: table vectors plus randomized columns against an image-level window model.
`default_nettype none

module tb_window_buffer_kxk;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         done3 = 1'b0;
  logic [23:0]  col3  = '0;
  logic [71:0]  win3;
  logic         dv3, pd3;
  logic [2:0]   cr3, cc3;

  logic         done9 = 1'b0;
  logic [71:0]  col9  = '0;
  logic [647:0] win9;
  logic         dv9, pd9;
  logic [3:0]   cr9, cc9;

  window_buffer_kxk #(.K(3), .DATA_W(8), .COLS(5), .ROWS(5)) dut3 (
    .clk(clk), .rst(rst), .done_i(done3), .col_i(col3), .window_o(win3),
    .done_o(dv3), .ctr_row_o(cr3), .ctr_col_o(cc3), .progress_done_o(pd3)
  );

  window_buffer_kxk #(.K(9), .DATA_W(8), .COLS(11), .ROWS(11)) dut9 (
    .clk(clk), .rst(rst), .done_i(done9), .col_i(col9), .window_o(win9),
    .done_o(dv9), .ctr_row_o(cr9), .ctr_col_o(cc9), .progress_done_o(pd9)
  );

  typedef struct {
    bit v;
    bit dv;
    bit pd;
    int cr;
    int cc;
  } vec_t;

  // One 5x5 frame with K=3; ctr fields only matter where dv=1.
  vec_t tbl [15] = '{
    '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}, '{1, 1, 0, 1, 1}, '{1, 1, 0, 1, 2}, '{1, 1, 0, 1, 3},
    '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}, '{1, 1, 0, 2, 1}, '{1, 1, 0, 2, 2}, '{1, 1, 0, 2, 3},
    '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}, '{1, 1, 0, 3, 1}, '{1, 1, 0, 3, 2}, '{1, 1, 1, 3, 3}
  };

  int tests = 0;
  int fails = 0;

  int           m      [2];
  logic [7:0]   img    [2][11][11];
  logic [647:0] ewin   [2];
  bit           known  [2];
  int           ecr    [2];
  int           ecc    [2];
  int           dv_cnt [2];
  int           pd_cnt [2];
  bit           rand_img = 1'b0;

  task automatic chk(input string name, input logic [647:0] act, input logic [647:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [647:0] w, output logic dv, output logic pd,
                        output int cr, output int cc);
    if (sel == 0) begin
      w = {576'b0, win3}; dv = dv3; pd = pd3; cr = int'(cr3); cc = int'(cc3);
    end else begin
      w = win9; dv = dv9; pd = pd9; cr = int'(cr9); cc = int'(cc9);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m[s] = 0; ewin[s] = '0; known[s] = 1'b1; ecr[s] = 0; ecc[s] = 0;
    end
  endtask

  task automatic check_zero();
    logic [647:0] w; logic dv, pd; int cr, cc;
    for (int s = 0; s < 2; s++) begin
      sample(s, w, dv, pd, cr, cc);
      chk("rst_window", w, '0);
      chk("rst_done", dv, 1'b0);
      chk("rst_progress", pd, 1'b0);
      chk("rst_ctr_row", cr, 0);
      chk("rst_ctr_col", cc, 0);
    end
  endtask

  // Called from a negedge; holds reset for two cycles.
  task automatic do_reset();
    done3 = 1'b0; done9 = 1'b0;
    rst = 1'b1;
    #1 check_zero();
    @(negedge clk); check_zero();
    @(negedge clk); check_zero();
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle on the selected DUT and check it against the image model at the following negedge.
  task automatic step(input int sel, input bit v);
    int k, rows, cols, half, ncol, i, j;
    logic [647:0] colv, w;
    logic dv, pd;
    int cr, cc;
    bit e_dv, e_pd;
    k = (sel == 0) ? 3 : 9;
    rows = (sel == 0) ? 5 : 11;
    cols = rows;
    half = (k - 1) / 2;
    ncol = (rows - k + 1) * cols;
    i = m[sel] / cols;
    j = m[sel] % cols;
    if (v && m[sel] == 0) begin
      for (int y = 0; y < rows; y++)
        for (int x = 0; x < cols; x++)
          img[sel][y][x] = rand_img ? 8'($urandom) : 8'(16 * y + x);
    end
    colv = '0;
    for (int r = 0; r < k; r++) colv[r*8 +: 8] = img[sel][i+r][j];
    if (sel == 0) begin done3 = v; col3 = colv[23:0]; end
    else          begin done9 = v; col9 = colv[71:0]; end
    @(posedge clk);
    e_dv = 1'b0; e_pd = 1'b0;
    if (v) begin
      if (j >= k - 1) begin
        e_dv = 1'b1;
        e_pd = (i == rows - k) && (j == cols - 1);
        ecr[sel] = i + half;
        ecc[sel] = j - half;
        ewin[sel] = '0;
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            ewin[sel][(r*k+c)*8 +: 8] = img[sel][i+r][j-(k-1)+c];
        known[sel] = 1'b1;
      end else begin
        known[sel] = 1'b0;
      end
      m[sel] = (m[sel] + 1) % ncol;
    end
    @(negedge clk);
    sample(sel, w, dv, pd, cr, cc);
    chk("done_o", dv, e_dv);
    chk("progress_done_o", pd, e_pd);
    if (e_dv) begin
      chk("ctr_row_o", cr, ecr[sel]);
      chk("ctr_col_o", cc, ecc[sel]);
    end
    if (known[sel]) chk("window_o", w, ewin[sel]);
    if (dv === 1'b1) dv_cnt[sel]++;
    if (pd === 1'b1) pd_cnt[sel]++;
    done3 = 1'b0; done9 = 1'b0;
  endtask

  task automatic run_table(input bit gaps);
    logic [71:0] exp1;
    bit ok;
    int d0, p0;
    d0 = dv_cnt[0]; p0 = pd_cnt[0];
    for (int n = 0; n < 15; n++) begin
      step(0, tbl[n].v);
      chk("tbl_done", dv3, tbl[n].dv);
      chk("tbl_progress", pd3, tbl[n].pd);
      if (tbl[n].dv) begin
        chk("tbl_ctr_row", int'(cr3), tbl[n].cr);
        chk("tbl_ctr_col", int'(cc3), tbl[n].cc);
      end
      if (n == 2) begin
        exp1 = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp1[(r*3+c)*8 +: 8] = 8'(16 * r + c);
        chk("first_window", win3, exp1);
      end
      if (n == 7) begin
        ok = 1'b1;
        for (int e = 0; e < 9; e++) if (win3[e*8 +: 8] < 8'd16) ok = 1'b0;
        chk("wrap_no_row0", ok, 1'b1);
      end
      if (gaps) step(0, 1'b0);
    end
    chk("frame_done_count", dv_cnt[0] - d0, 9);
    chk("frame_progress_count", pd_cnt[0] - p0, 1);
  endtask

  initial begin
    int d0, p0, d9, p9;
    for (int s = 0; s < 2; s++) begin dv_cnt[s] = 0; pd_cnt[s] = 0; end
    model_reset();
    @(negedge clk);
    do_reset();

    run_table(1'b0);
    run_table(1'b1);

    for (int n = 0; n < 7; n++) step(0, 1'b1);
    do_reset();
    run_table(1'b0);

    d0 = dv_cnt[0]; p0 = pd_cnt[0];
    for (int n = 0; n < 30; n++) step(0, 1'b1);
    chk("two_frame_done_count", dv_cnt[0] - d0, 18);
    chk("two_frame_progress_count", pd_cnt[0] - p0, 2);

    d9 = dv_cnt[1]; p9 = pd_cnt[1];
    for (int n = 0; n < 33; n++) step(1, 1'b1);
    chk("k9_done_count", dv_cnt[1] - d9, 9);
    chk("k9_progress_count", pd_cnt[1] - p9, 1);

    rand_img = 1'b1;
    do_reset();
    for (int n = 0; n < 600; n++) step(int'($urandom_range(1, 0)), ($urandom % 3) != 0);
    do_reset();
    for (int n = 0; n < 200; n++) step(int'($urandom_range(1, 0)), ($urandom % 4) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
